// File: rtl/line_compositor.sv
// Scanline output stage: LAYERS ping-pong line buffers merged by priority, palette lookup,
// and sync signals delayed to stay aligned with the registered RGB.
module line_compositor #(
   parameter int H_RES   = 640,
   parameter int IDX_W   = 8,
   parameter int LAYERS  = 2,
   parameter int RGB_W   = 4,
   parameter int PAL_LAT = 1,
   parameter int XW      = 10
) (
   input  logic                      clk_pix,
   input  logic                      btn_rst,
   input  logic                      line_start,
   input  logic [LAYERS-1:0]         wr_en,
   input  logic [LAYERS*XW-1:0]      wr_addr,
   input  logic [LAYERS*IDX_W-1:0]   wr_data,
   input  logic [XW-1:0]             sx,
   input  logic                      de,
   input  logic                      hsync_in,
   input  logic                      vsync_in,
   input  logic [IDX_W-1:0]          bg_idx,
   output logic [IDX_W-1:0]          pal_addr,
   input  logic [23:0]               pal_data,
   output logic [RGB_W-1:0]          vga_r,
   output logic [RGB_W-1:0]          vga_g,
   output logic [RGB_W-1:0]          vga_b,
   output logic                      vga_hsync,
   output logic                      vga_vsync,
   output logic                      ready,
   output logic [LAYERS-1:0]         wr_drop
);

   localparam int LAT = 3 + PAL_LAT;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              r_state, w_state_next;
   logic [XW-1:0]       r_clr_cnt, w_clr_cnt_next;
   logic                r_ready;
   logic                r_front;
   logic                w_run;

   logic [XW-1:0]       r_s0_sx;
   logic                r_s0_bank, r_s0_de, r_s0_inr;
   logic                w_sx_inr, w_de_run, w_clr_en;
   logic [XW-1:0]       w_rd_addr;

   logic [LAYERS-1:0]   w_wr_ok, w_drop, r_wr_drop;
   logic [IDX_W-1:0]    w_layer_idx [LAYERS];
   logic [IDX_W-1:0]    w_merged, r_pal_addr;

   logic [2:0]          r_dly [LAT-1];
   logic                w_dly_de;
   logic [RGB_W-1:0]    r_vga_r, r_vga_g, r_vga_b;
   logic                r_vga_hs, r_vga_vs;
   logic                w_unused;

   always_ff @(posedge clk_pix or negedge btn_rst) begin
      if (!btn_rst) begin
         r_state   <= S_INIT;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_clr_cnt <= w_clr_cnt_next;
         r_ready   <= (w_state_next == S_RUN);
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_clr_cnt_next = r_clr_cnt;
      case (r_state)
         S_INIT: begin
            if (r_clr_cnt == XW'(H_RES - 1)) w_state_next = S_RUN;
            else                             w_clr_cnt_next = r_clr_cnt + XW'(1);
         end
         default: ;
      endcase
   end

   assign w_run     = (r_state == S_RUN);
   assign w_de_run  = de & w_run;
   assign w_sx_inr  = ({1'b0, sx} < (XW+1)'(H_RES));
   assign w_rd_addr = w_sx_inr ? sx : '0;
   assign w_clr_en  = r_s0_de & r_s0_inr;

   // Stage 0: the bank is captured with the pixel so a mid-line swap never splits a pixel.
   always_ff @(posedge clk_pix or negedge btn_rst) begin
      if (!btn_rst) begin
         r_front   <= 1'b0;
         r_s0_sx   <= '0;
         r_s0_bank <= 1'b0;
         r_s0_de   <= 1'b0;
         r_s0_inr  <= 1'b0;
         r_wr_drop <= '0;
      end else begin
         r_front   <= r_front ^ (w_run & line_start);
         r_s0_sx   <= sx;
         r_s0_bank <= r_front;
         r_s0_de   <= w_de_run;
         r_s0_inr  <= w_sx_inr;
         r_wr_drop <= w_drop;
      end
   end

   genvar gi, gb;
   generate
      for (gi = 0; gi < LAYERS; gi++) begin : g_layer
         logic [XW-1:0]    w_wa;
         logic [IDX_W-1:0] w_wd;
         logic             w_wa_inr;
         logic [IDX_W-1:0] w_rd_bank [2];

         assign w_wa        = wr_addr[gi*XW +: XW];
         assign w_wd        = wr_data[gi*IDX_W +: IDX_W];
         assign w_wa_inr    = ({1'b0, w_wa} < (XW+1)'(H_RES));
         assign w_wr_ok[gi] = w_run & wr_en[gi] & w_wa_inr;
         assign w_drop[gi]  = w_run & wr_en[gi] & ~w_wa_inr;

         for (gb = 0; gb < 2; gb++) begin : g_bank
            logic [IDX_W-1:0] r_mem [H_RES];
            logic [IDX_W-1:0] r_rd;

            // A drawer write after the clear wins when both hit the same entry just after a swap.
            always_ff @(posedge clk_pix) begin
               if (!w_run) begin
                  r_mem[r_clr_cnt] <= '0;
               end else begin
                  if (w_clr_en && (r_s0_bank == 1'(gb))) r_mem[r_s0_sx] <= '0;
                  if (w_wr_ok[gi] && (r_front != 1'(gb))) r_mem[w_wa] <= w_wd;
               end
               r_rd <= r_mem[w_rd_addr];
            end

            assign w_rd_bank[gb] = r_rd;
         end

         assign w_layer_idx[gi] = r_s0_inr ? w_rd_bank[r_s0_bank] : '0;
      end
   endgenerate

   always_comb begin
      w_merged = bg_idx;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (w_layer_idx[i] != '0) w_merged = w_layer_idx[i];
      end
   end

   assign w_dly_de = r_dly[LAT-2][2];

   always_ff @(posedge clk_pix or negedge btn_rst) begin
      if (!btn_rst) begin
         r_pal_addr <= '0;
         for (int k = 0; k < LAT - 1; k++) r_dly[k] <= '0;
         r_vga_r  <= '0;
         r_vga_g  <= '0;
         r_vga_b  <= '0;
         r_vga_hs <= 1'b0;
         r_vga_vs <= 1'b0;
      end else begin
         r_pal_addr <= r_s0_de ? w_merged : '0;
         r_dly[0]   <= {w_de_run, hsync_in, vsync_in};
         for (int k = 1; k < LAT - 1; k++) r_dly[k] <= r_dly[k-1];
         r_vga_r  <= w_dly_de ? pal_data[23 -: RGB_W] : '0;
         r_vga_g  <= w_dly_de ? pal_data[15 -: RGB_W] : '0;
         r_vga_b  <= w_dly_de ? pal_data[7 -: RGB_W]  : '0;
         r_vga_hs <= r_dly[LAT-2][1];
         r_vga_vs <= r_dly[LAT-2][0];
      end
   end

   assign w_unused  = ^pal_data;
   assign pal_addr  = r_pal_addr;
   assign vga_r     = r_vga_r;
   assign vga_g     = r_vga_g;
   assign vga_b     = r_vga_b;
   assign vga_hsync = r_vga_hs;
   assign vga_vsync = r_vga_vs;
   assign ready     = r_ready;
   assign wr_drop   = r_wr_drop;

endmodule

// File: tb/tb_line_compositor.sv
// Randomized and directed checks of line_compositor against a per-bank array model.
module tb_line_compositor;

   localparam int H_RES  = 640;
   localparam int IDX_W  = 8;
   localparam int LAYERS = 2;
   localparam int RGB_W  = 4;
   localparam int XW     = 10;
   localparam int NSTEP  = 8192;

   logic                    clk_pix = 1'b0;
   logic                    btn_rst = 1'b1;
   logic                    line_start = 1'b0;
   logic [LAYERS-1:0]       wr_en = '0;
   logic [LAYERS*XW-1:0]    wr_addr = '0;
   logic [LAYERS*IDX_W-1:0] wr_data = '0;
   logic [XW-1:0]           sx = '0;
   logic                    de = 1'b0;
   logic                    hsync_in = 1'b0;
   logic                    vsync_in = 1'b0;
   logic [IDX_W-1:0]        bg_idx = 8'h01;
   logic [IDX_W-1:0]        pal_addr;
   logic [23:0]             pal_data = '0;
   logic [RGB_W-1:0]        vga_r, vga_g, vga_b;
   logic                    vga_hsync, vga_vsync, ready;
   logic [LAYERS-1:0]       wr_drop;

   line_compositor #(.H_RES(H_RES), .IDX_W(IDX_W), .LAYERS(LAYERS), .RGB_W(RGB_W),
                     .PAL_LAT(1), .XW(XW)) dut (
      .clk_pix(clk_pix), .btn_rst(btn_rst), .line_start(line_start),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sx(sx), .de(de), .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_idx(bg_idx),
      .pal_addr(pal_addr), .pal_data(pal_data),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .ready(ready), .wr_drop(wr_drop)
   );

   always #5 clk_pix = ~clk_pix;

   // Palette memory with one cycle of read latency.
   logic [23:0] pal_mem [256];
   always @(posedge clk_pix) pal_data <= pal_mem[pal_addr];

   // Reference model: two banks of per-layer lines, plus expected outputs per edge.
   logic [7:0]  mb [2][LAYERS][H_RES];
   logic        m_front, m_run, pc_v, pc_bank;
   int          m_cnt, pc_sx, n;
   logic [7:0]  e_pal  [NSTEP];
   logic [11:0] e_rgb  [NSTEP];
   logic [1:0]  e_sync [NSTEP];
   logic [1:0]  e_drop [NSTEP];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (step %0d)", tag, got, exp, n);
      end
   endtask

   task automatic model_reset();
      m_front = 1'b0; m_run = 1'b0; m_cnt = 0; pc_v = 1'b0; pc_bank = 1'b0; pc_sx = 0;
      for (int b = 0; b < 2; b++)
         for (int l = 0; l < LAYERS; l++)
            for (int a = 0; a < H_RES; a++) mb[b][l][a] = 8'h00;
      for (int i = 0; i < NSTEP; i++) begin
         e_pal[i] = '0; e_rgb[i] = '0; e_sync[i] = '0; e_drop[i] = '0;
      end
   endtask

   task automatic clr_in();
      line_start = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; sx = '0; de = 1'b0;
   endtask

   // One clock: advance the model with this cycle's inputs, then compare every output.
   task automatic step();
      logic [7:0] merged, v;
      logic [1:0] drop;
      int a;
      n++;
      @(posedge clk_pix);
      if (m_run) begin
         if (de) begin
            merged = bg_idx;
            if (int'(sx) < H_RES)
               for (int l = LAYERS - 1; l >= 0; l--) begin
                  v = mb[m_front][l][sx];
                  if (v != 8'h00) merged = v;
               end
            e_pal[n+1] = merged;
            e_rgb[n+3] = {pal_mem[merged][23:20], pal_mem[merged][15:12], pal_mem[merged][7:4]};
         end else begin
            e_pal[n+1] = '0;
            e_rgb[n+3] = '0;
         end
         if (pc_v) for (int l = 0; l < LAYERS; l++) mb[pc_bank][l][pc_sx] = 8'h00;
         drop = '0;
         for (int l = 0; l < LAYERS; l++) begin
            if (wr_en[l]) begin
               a = int'(wr_addr[l*XW +: XW]);
               if (a < H_RES) mb[m_front ^ 1'b1][l][a] = wr_data[l*IDX_W +: IDX_W];
               else drop[l] = 1'b1;
            end
         end
         e_drop[n] = drop;
         pc_v = de && (int'(sx) < H_RES);
         pc_bank = m_front;
         pc_sx = int'(sx);
         if (line_start) m_front = ~m_front;
      end else begin
         e_pal[n+1] = '0;
         e_rgb[n+3] = '0;
         e_drop[n] = '0;
         pc_v = 1'b0;
         if (m_cnt == H_RES - 1) m_run = 1'b1;
         else m_cnt++;
      end
      e_sync[n+3] = {hsync_in, vsync_in};
      #1;
      chk("pal_addr", pal_addr, e_pal[n]);
      chk("rgb", {vga_r, vga_g, vga_b}, e_rgb[n]);
      chk("sync", {vga_hsync, vga_vsync}, e_sync[n]);
      chk("wr_drop", wr_drop, e_drop[n]);
      chk("ready", ready, m_run);
   endtask

   task automatic do_reset();
      #2 btn_rst = 1'b0;
      #1;
      chk("rst_pal", pal_addr, 8'h00);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      chk("rst_sync", {vga_hsync, vga_vsync}, 2'b00);
      chk("rst_ready", ready, 1'b0);
      chk("rst_drop", wr_drop, 2'b00);
      model_reset();
      repeat (2) @(posedge clk_pix);
      #1 btn_rst = 1'b1;
   endtask

   // INIT with junk inputs that must all be ignored.
   task automatic run_init();
      for (int k = 1; k <= H_RES; k++) begin
         de = 1'($urandom_range(0, 1));
         sx = XW'($urandom_range(0, 1023));
         wr_en = LAYERS'($urandom_range(0, 3));
         wr_addr = 20'($urandom);
         wr_data = 16'($urandom);
         line_start = 1'($urandom_range(0, 1));
         hsync_in = 1'($urandom_range(0, 1));
         step();
         if (k == H_RES - 1) chk("ready_low", ready, 1'b0);
         if (k == H_RES) chk("ready_high", ready, 1'b1);
      end
      clr_in();
      hsync_in = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) pal_mem[i] = 24'($urandom);
      pal_mem[8'h22] = 24'hA0B0C0;
      n = 0;
      do_reset();
      run_init();
      repeat (4) step();

      // Priority with a transparent layer 0
      wr_en = 2'b11; wr_addr = {10'd5, 10'd5}; wr_data = {8'h22, 8'h00}; bg_idx = 8'h01;
      step();
      clr_in(); line_start = 1'b1; step();
      clr_in(); sx = 10'd5; de = 1'b1; step();
      clr_in(); step();
      chk("prio_pal", pal_addr, 8'h22);
      step(); step();
      chk("prio_rgb", {vga_r, vga_g, vga_b}, 12'hABC);

      // Layer 0 wins over layer 1
      wr_en = 2'b11; wr_addr = {10'd7, 10'd7}; wr_data = {8'h22, 8'h10}; step();
      clr_in(); line_start = 1'b1; step();
      clr_in(); sx = 10'd7; de = 1'b1; step();
      clr_in(); step();
      chk("layer0_pal", pal_addr, 8'h10);
      repeat (3) step();

      // Out-of-range write on layer 0, legal write on layer 1
      wr_en = 2'b11; wr_addr = {10'd639, 10'd640}; wr_data = {8'h44, 8'h55}; step();
      chk("drop_pulse", wr_drop, 2'b01);
      clr_in(); step();
      chk("drop_end", wr_drop, 2'b00);
      wr_en = 2'b10; wr_addr = {10'd1023, 10'd0}; step();
      chk("drop_l1", wr_drop, 2'b10);
      clr_in(); step();

      // Write in the same cycle as the swap
      sx = 10'd3; de = 1'b1; step();
      clr_in(); line_start = 1'b1; wr_en = 2'b01; wr_addr = {10'd0, 10'd3}; wr_data = {8'h00, 8'h33};
      step();
      chk("collide_old", pal_addr, 8'h01);
      clr_in(); sx = 10'd3; de = 1'b1; step();
      clr_in(); step();
      chk("collide_new", pal_addr, 8'h33);
      repeat (3) step();

      // Sync alignment
      hsync_in = 1'b1;
      step(); chk("hs_d1", vga_hsync, 1'b0);
      step(); chk("hs_d2", vga_hsync, 1'b0);
      step(); chk("hs_d3", vga_hsync, 1'b0);
      step(); chk("hs_d4", vga_hsync, 1'b1);
      hsync_in = 1'b0;
      repeat (4) step();
      chk("hs_fall", vga_hsync, 1'b0);

      // Random drawing while displaying, with blanking and a mid-line swap
      bg_idx = 8'h5C;
      step(); step();
      for (int ln = 0; ln < 3; ln++) begin
         for (int k = 0; k < H_RES + 40; k++) begin
            clr_in();
            if (k < H_RES) begin
               sx = XW'(k); de = 1'b1;
            end else if (k < H_RES + 35) begin
               sx = XW'($urandom_range(0, 1023)); de = 1'($urandom_range(0, 1));
            end
            hsync_in = (k >= H_RES + 10) && (k < H_RES + 25);
            vsync_in = (ln == 1);
            for (int l = 0; l < LAYERS; l++) begin
               if ($urandom_range(0, 3) == 0) begin
                  wr_en[l] = 1'b1;
                  wr_addr[l*XW +: XW] = XW'($urandom_range(0, H_RES + 20));
                  wr_data[l*IDX_W +: IDX_W] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
               end
            end
            if ((ln == 2 && k == 300) || k == H_RES + 39) line_start = 1'b1;
            step();
         end
      end

      // Read-and-clear: after three undrawn lines every pixel shows the background
      for (int ln = 0; ln < 3; ln++) begin
         for (int k = 0; k <= H_RES + 4; k++) begin
            clr_in();
            if (k < H_RES) begin sx = XW'(k); de = 1'b1; end
            if (k == H_RES + 4) line_start = 1'b1;
            step();
            if (ln == 2 && k >= 1 && k <= H_RES) chk("clear_bg", pal_addr, bg_idx);
         end
      end

      // Asynchronous reset mid-line, then a full re-initialisation
      hsync_in = 1'b1; vsync_in = 1'b1;
      for (int k = 0; k < 100; k++) begin clr_in(); sx = XW'(k); de = 1'b1; step(); end
      do_reset();
      run_init();
      for (int k = 0; k < H_RES + 8; k++) begin
         clr_in();
         if (k < H_RES) begin sx = XW'(k); de = 1'b1; end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/line_compositor.md
# line_compositor

Parametrised scanline output stage between the line-drawing engines (sprite and tile drawers) and the VGA pins. It holds LAYERS ping-pong line buffers of palette indices, swaps banks on each line start, merges the layers by fixed priority with index-0 transparency, looks the winning index up in palette memory, and drives registered RGB. The VGA syncs are delayed by the same amount so they stay aligned with the pixels. Each front-bank entry is cleared as it is displayed, so drawers always start a line on an all-transparent back bank.

## Interface
Parameters:
- H_RES, 640, active pixels per line; buffer depth.
- IDX_W, 8, palette index width.
- LAYERS, 2, number of layers; layer 0 has the highest priority.
- RGB_W, 4, output bits per colour channel (1..8).
- PAL_LAT, 1, palette read latency in clk_pix cycles (≥1).
- XW, 10, column address width; must satisfy 2^XW ≥ H_RES.

Ports:
- clk_pix, in, 1, pixel clock; the only clock.
- btn_rst, in, 1, reset; asynchronous, active-low.
- line_start, in, 1, one-cycle pulse per line that swaps the front and back banks.
- wr_en, in, LAYERS, per-layer write strobe into the back bank.
- wr_addr, in, LAYERS×XW, per-layer column.
- wr_data, in, LAYERS×IDX_W, per-layer palette index; 0 means transparent.
- sx, in, XW, current display column.
- de, in, 1, display enable for sx.
- hsync_in, in, 1, raw horizontal sync.
- vsync_in, in, 1, raw vertical sync.
- bg_idx, in, IDX_W, background index, used when every layer is 0.
- pal_addr, out, IDX_W, palette read address; registered.
- pal_data, in, 24, palette entry as {R[7:0], G[7:0], B[7:0]}; valid PAL_LAT cycles after pal_addr.
- vga_r, out, RGB_W, red.
- vga_g, out, RGB_W, green.
- vga_b, out, RGB_W, blue.
- vga_hsync, out, 1, delayed hsync_in.
- vga_vsync, out, 1, delayed vsync_in.
- ready, out, 1, high once the initial clear is complete.
- wr_drop, out, LAYERS, one-cycle pulse per rejected write.

## Operation
- Storage: 2 banks × LAYERS × H_RES × IDX_W. `front` is a 1-bit bank select.
  - Reads and clears address bank `front`.
  - Drawer writes address bank `!front`.
- Reset (asserted asynchronously):
  - State INIT, `front`=0, clear counter=0.
  - All pipeline registers 0, so every output is 0: pal_addr, vga_*, vga_hsync, vga_vsync, ready, wr_drop.
- INIT state:
  - Each cycle writes 0 to address `counter` in both banks of every layer.
  - After H_RES cycles: RUN, and `ready`=1.
  - While in INIT: wr_en and line_start are ignored, and RGB outputs are forced to 0. The sync delay line keeps running.
- RUN state, swap:
  - line_start=1 toggles `front` on the next edge.
  - A write in the same cycle as line_start lands in the pre-swap back bank.
- RUN state, writes:
  - wr_en[i] with wr_addr[i] < H_RES writes wr_data[i] to layer i of the back bank.
  - wr_addr[i] ≥ H_RES: the write is discarded and wr_drop[i] pulses on the next cycle.
  - Layers are independent; simultaneous writes to all layers are legal.
- RUN state, pixel pipeline:
  - S0: sample sx, de, and `front` into stage-0 registers.
  - S1: read all layers of the stage-0 bank at stage-0 sx. If stage-0 de=1, write 0 to that same entry (read-and-clear).
  - S2: merge. Take the lowest-numbered layer with a nonzero index; if none, use bg_idx. pal_addr ← merged index when de=1, else 0.
  - S3 (PAL_LAT cycles after S2): vga_c ← pal_data[8k+7 -: RGB_W] for c = b, g, r with k = 0, 1, 2, when delayed de=1; otherwise 0.
- Sync path: hsync_in, vsync_in, and de go through a shift register of length LAT, so the delayed de gates RGB.
- Swap with reads in flight: each pixel uses the bank captured at S0. Asserting line_start while de=1 is legal; pixels sampled before the swap still come from the old bank.
- An sx ≥ H_RES with de=1 reads as transparent (bg_idx) and performs no clear.

## Timing
- LAT = 3 + PAL_LAT cycles, from sx/de/hsync_in to vga_* and vga_hsync/vga_vsync. With the default PAL_LAT=1, LAT=4.
- pal_addr is valid 2 cycles after sx.
- A write to the back bank is visible after the next line_start. The earliest read is a sample taken one cycle after the swap edge.
- Throughput is one pixel per cycle with no stalls.
- ready rises H_RES cycles after btn_rst deasserts.

## Test plan
- Reset release: wait H_RES=640 cycles → ready rises on cycle 640. All outputs are 0 before that; both banks read 0 (bg_idx shown).
- Priority: back bank gets layer0[5]=0x00 and layer1[5]=0x22, bg_idx=0x01, then line_start. Present sx=5, de=1 → pal_addr=0x22 at +2; with pal_data=0xA0B0C0, RGB = A/B/C at +4.
- Layer 0 wins: layer0[7]=0x10 and layer1[7]=0x22 → pal_addr=0x10.
- Read-and-clear: display a full line, swap twice with no writes, display again → every pixel uses bg_idx.
- Bad address: wr_addr=640 with wr_en=1 → wr_drop pulses one cycle later; no buffer change.
- Swap collision: line_start and a write to col 3 in the same cycle → the value appears on the next line, not the current one.
- Alignment: hsync_in toggles at cycle t → vga_hsync toggles at t+4. Asynchronous reset mid-line → all outputs 0 immediately, INIT restarts.
